// File: rtl/axis_wrr_arbiter.sv
// Packet-level weighted round-robin arbiter. Grants one source at a time and
// holds that grant until the packet ends or a beat-inactivity timeout fires.
// Each source gets max(weight, 1) packets per round before credits reload.
module axis_wrr_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned WEIGHT_WIDTH    = 4,
    parameter int unsigned TIMEOUT_CNT_MAX = 128,
    parameter int unsigned IDX_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [WEIGHT_WIDTH*NUM_REQ-1:0] weights,
    input  logic                            beat,
    input  logic                            last,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            grant_valid,
    output logic [IDX_W-1:0]                grant_idx,
    output logic                            timeout_pulse,
    output logic [15:0]                     timeout_count
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CNT_MAX) + 1;

    if (NUM_REQ < 1 || NUM_REQ > 8) begin : gen_bad_num_req
        $error("axis_wrr_arbiter: NUM_REQ must be in 1..8");
    end

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                    state_q, state_d;
    logic [WEIGHT_WIDTH-1:0]   credit_q [NUM_REQ];
    logic [WEIGHT_WIDTH-1:0]   credit_d [NUM_REQ];
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [TIMER_W-1:0]        timer_q, timer_d;
    logic [NUM_REQ-1:0]        grant_q, grant_d;
    logic                      grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]          grant_idx_q, grant_idx_d;
    logic                      timeout_pulse_q, timeout_pulse_d;
    logic [15:0]               timeout_count_q, timeout_count_d;

    logic [NUM_REQ-1:0]        elig;
    logic                      sel_found;
    logic [IDX_W-1:0]          sel_idx;
    logic [IDX_W-1:0]          cand_idx;
    int unsigned               cand;
    int unsigned               ptr_inc_full;
    logic [IDX_W-1:0]          ptr_inc;

    // Eligible sources: requesting and still holding credit this round.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            elig[i] = req[i] && (credit_q[i] != '0);
        end
    end

    // Round-robin pick: first eligible source scanning upward from ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand     = (32'(ptr_q) + k) % NUM_REQ;
            cand_idx = cand[IDX_W-1:0];
            if (!sel_found && elig[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    // Source after the current grant, modulo NUM_REQ.
    always_comb begin
        ptr_inc_full = (32'(grant_idx_q) + 1) % NUM_REQ;
        ptr_inc      = ptr_inc_full[IDX_W-1:0];
    end

    // Next-state logic: reload, grant selection, packet end and timeout release.
    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        ptr_d           = ptr_q;
        timer_d         = timer_q;
        grant_d         = grant_q;
        grant_valid_d   = grant_valid_q;
        grant_idx_d     = grant_idx_q;
        timeout_pulse_d = 1'b0;
        timeout_count_d = timeout_count_q;

        unique case (state_q)
            StIdle: begin
                if (req != '0) begin
                    if (elig == '0) begin
                        // Round exhausted: weight 0 still buys one packet.
                        for (int unsigned i = 0; i < NUM_REQ; i++) begin
                            if (weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0) begin
                                credit_d[i] = WEIGHT_WIDTH'(1);
                            end else begin
                                credit_d[i] = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                            end
                        end
                    end else begin
                        grant_d          = '0;
                        grant_d[sel_idx] = 1'b1;
                        grant_idx_d      = sel_idx;
                        grant_valid_d    = 1'b1;
                        timer_d          = '0;
                        state_d          = StLocked;
                    end
                end
            end
            StLocked: begin
                if (beat && last) begin
                    if (credit_q[grant_idx_q] != '0) begin
                        credit_d[grant_idx_q] = credit_q[grant_idx_q] - WEIGHT_WIDTH'(1);
                    end
                    // Keep priority while this source still has credit.
                    if (credit_q[grant_idx_q] <= WEIGHT_WIDTH'(1)) begin
                        ptr_d = ptr_inc;
                    end else begin
                        ptr_d = grant_idx_q;
                    end
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    grant_idx_d   = '0;
                    state_d       = StIdle;
                end else if (beat) begin
                    timer_d = '0;
                end else if (timer_q == TIMER_W'(TIMEOUT_CNT_MAX - 1)) begin
                    // Stalled packet: forfeit remaining credit and move on.
                    credit_d[grant_idx_q] = '0;
                    ptr_d                 = ptr_inc;
                    timeout_pulse_d       = 1'b1;
                    if (timeout_count_q != 16'hFFFF) begin
                        timeout_count_d = timeout_count_q + 16'd1;
                    end
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    grant_idx_d   = '0;
                    state_d       = StIdle;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                credit_q[i] <= '0;
            end
            ptr_q           <= '0;
            timer_q         <= '0;
            grant_q         <= '0;
            grant_valid_q   <= 1'b0;
            grant_idx_q     <= '0;
            timeout_pulse_q <= 1'b0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                credit_q[i] <= credit_d[i];
            end
            ptr_q           <= ptr_d;
            timer_q         <= timer_d;
            grant_q         <= grant_d;
            grant_valid_q   <= grant_valid_d;
            grant_idx_q     <= grant_idx_d;
            timeout_pulse_q <= timeout_pulse_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign grant         = grant_q;
    assign grant_valid   = grant_valid_q;
    assign grant_idx     = grant_idx_q;
    assign timeout_pulse = timeout_pulse_q;
    assign timeout_count = timeout_count_q;

endmodule
